// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared types and default sizes for the UART receive-side controller.
//   to_state_t : idle-timeout FSM states
//   *_DEF      : default parameter values used by the controller and its interface
package uart_rx_pkg;

   localparam int DEPTH_DEF = 8;
   localparam int DW_DEF    = 9;
   localparam int DIV_W_DEF = 16;
   localparam int TO_W_DEF  = 8;

   typedef enum logic [1:0] {
      TO_IDLE  = 2'd0,
      TO_COUNT = 2'd1,
      TO_FIRED = 2'd2
   } to_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//   Valid/ready pop port between the receive FIFO and the AHB register block.
//   rd_valid : FIFO non-empty                (master -> slave)
//   rd_data  : FIFO head word, 0 when empty  (master -> slave)
//   rd_ready : pop request                   (slave -> master)
interface uart_rx_ctrl_if
   import uart_rx_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   DEPTH x DW register FIFO with extra-bit pointers (level = wr_ptr - rd_ptr).
//   clk, resetn : clock, asynchronous active-low reset
//   i_push/i_data : write request and word; refused when full unless a pop
//                   happens in the same cycle
//   i_pop       : pop request; ignored when empty
//   i_flush     : synchronous clear, wins over push and pop
//   o_data      : head word (combinational), 0 when empty
//   o_full, o_empty, o_level : occupancy flags and count 0..DEPTH
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 9
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_push,
   input  logic [DW-1:0]            i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [DW-1:0]            o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [DW-1:0] r_mem [DEPTH];

   logic [PW-1:0] w_level;
   logic          w_pop;
   logic          w_wr;

   assign w_level = r_wr_ptr - r_rd_ptr;
   assign o_level = w_level;
   assign o_empty = (w_level == '0);
   assign o_full  = (w_level == PW'(DEPTH));

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign w_pop = i_pop & ~o_empty & ~i_flush;
   assign w_wr  = i_push & (~o_full | w_pop) & ~i_flush;

   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset: the head is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side controller for the AHB UART: 16x oversample tick generator,
//   receive word FIFO with valid/ready pop port, and interrupt generation.
//   clk, resetn   : clock, asynchronous active-low reset
//   i_enable      : receiver enable (stops ticks, ignores pushes)
//   i_baud_div    : tick period in clk cycles, 0 = no ticks
//   o_b_tick      : one-cycle oversample tick to UART_RX
//   i_rx_done/i_rx_data : word-complete pulse and word from UART_RX
//   rd_if         : pop port (master side)
//   o_level       : FIFO occupancy
//   i_thresh      : level interrupt threshold, 0 = disabled
//   i_to_limit    : idle timeout in ticks, 0 = disabled
//   i_flush, i_ovr_clr : FIFO clear, sticky overrun clear
//   o_overrun, o_timeout, o_irq : status and registered interrupt
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF,
   parameter int DIV_W = DIV_W_DEF,
   parameter int TO_W  = TO_W_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    i_enable,
   input  logic [DIV_W-1:0]        i_baud_div,
   output logic                    o_b_tick,
   input  logic                    i_rx_done,
   input  logic [DW-1:0]           i_rx_data,
   uart_rx_ctrl_if.master          rd_if,
   output logic [$clog2(DEPTH):0]  o_level,
   input  logic [$clog2(DEPTH):0]  i_thresh,
   input  logic [TO_W-1:0]         i_to_limit,
   input  logic                    i_flush,
   input  logic                    i_ovr_clr,
   output logic                    o_overrun,
   output logic                    o_timeout,
   output logic                    o_irq
);
   // ---------------- baud tick ----------------
   logic [DIV_W-1:0] r_baud_cnt;
   logic             r_b_tick;

   // Using >= instead of == lets a divisor lowered below the count wrap at once.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_baud_cnt <= '0;
         r_b_tick   <= 1'b0;
      end else if (!i_enable || i_baud_div == '0) begin
         r_baud_cnt <= '0;
         r_b_tick   <= 1'b0;
      end else if (r_baud_cnt >= i_baud_div - DIV_W'(1)) begin
         r_baud_cnt <= '0;
         r_b_tick   <= 1'b1;
      end else begin
         r_baud_cnt <= r_baud_cnt + DIV_W'(1);
         r_b_tick   <= 1'b0;
      end
   end

   assign o_b_tick = r_b_tick;

   // ---------------- FIFO ----------------
   logic                   w_push;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_drop;
   logic [DW-1:0]          w_head;
   logic [$clog2(DEPTH):0] w_level;

   assign w_push = i_rx_done & i_enable;
   assign w_pop  = rd_if.rd_valid & rd_if.rd_ready;
   assign w_drop = w_push & w_full & ~w_pop & ~i_flush;

   uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push),
      .i_data  (i_rx_data),
      .i_pop   (w_pop),
      .i_flush (i_flush),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign rd_if.rd_valid = ~w_empty;
   assign rd_if.rd_data  = w_head;
   assign o_level        = w_level;

   // ---------------- overrun ----------------
   logic r_overrun;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        r_overrun <= 1'b0;
      else if (w_drop)    r_overrun <= 1'b1;
      else if (i_ovr_clr) r_overrun <= 1'b0;
   end

   assign o_overrun = r_overrun;

   // ---------------- idle timeout ----------------
   to_state_t       r_to_state, w_to_state_nx;
   logic [TO_W-1:0] r_to_cnt, w_to_cnt_nx, w_to_cnt_inc;
   logic            w_to_stop;
   logic            w_act;

   assign w_to_cnt_inc = r_to_cnt + TO_W'(1);
   assign w_to_stop    = i_flush | w_empty | (i_to_limit == '0);
   assign w_act        = w_push | w_pop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_to_state <= TO_IDLE;
         r_to_cnt   <= '0;
      end else begin
         r_to_state <= w_to_state_nx;
         r_to_cnt   <= w_to_cnt_nx;
      end
   end

   always_comb begin
      w_to_state_nx = r_to_state;
      w_to_cnt_nx   = r_to_cnt;
      case (r_to_state)
         TO_IDLE: begin
            w_to_cnt_nx = '0;
            if (!w_to_stop) w_to_state_nx = TO_COUNT;
         end
         TO_COUNT: begin
            if (w_to_stop) begin
               w_to_state_nx = TO_IDLE;
               w_to_cnt_nx   = '0;
            end else if (w_act) begin
               w_to_cnt_nx   = '0;
            end else if (r_to_cnt >= i_to_limit) begin
               // limit was lowered under the running count
               w_to_state_nx = TO_FIRED;
            end else if (r_b_tick) begin
               w_to_cnt_nx = w_to_cnt_inc;
               if (w_to_cnt_inc == i_to_limit) w_to_state_nx = TO_FIRED;
            end
         end
         TO_FIRED: begin
            if (w_to_stop) begin
               w_to_state_nx = TO_IDLE;
               w_to_cnt_nx   = '0;
            end else if (w_act) begin
               w_to_state_nx = TO_COUNT;
               w_to_cnt_nx   = '0;
            end
         end
         default: begin
            w_to_state_nx = TO_IDLE;
            w_to_cnt_nx   = '0;
         end
      endcase
   end

   assign o_timeout = (r_to_state == TO_FIRED);

   // ---------------- interrupt ----------------
   logic r_irq;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_irq <= 1'b0;
      else         r_irq <= ((i_thresh != '0) && (w_level >= i_thresh)) | o_timeout | r_overrun;
   end

   assign o_irq = r_irq;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
   localparam int DEPTH = 8;
   localparam int DW    = 9;

   logic          clk;
   logic          resetn;
   logic          enable;
   logic [15:0]   baud_div;
   logic          b_tick;
   logic          rx_done;
   logic [DW-1:0] rx_data;
   logic [3:0]    level;
   logic [3:0]    thresh;
   logic [7:0]    to_limit;
   logic          flush;
   logic          ovr_clr;
   logic          overrun;
   logic          timeout;
   logic          irq;

   uart_rx_ctrl_if #(.DW(DW)) rd_if ();

   uart_rx_ctrl #(.DEPTH(DEPTH), .DW(DW), .DIV_W(16), .TO_W(8)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .i_enable   (enable),
      .i_baud_div (baud_div),
      .o_b_tick   (b_tick),
      .i_rx_done  (rx_done),
      .i_rx_data  (rx_data),
      .rd_if      (rd_if.master),
      .o_level    (level),
      .i_thresh   (thresh),
      .i_to_limit (to_limit),
      .i_flush    (flush),
      .i_ovr_clr  (ovr_clr),
      .o_overrun  (overrun),
      .o_timeout  (timeout),
      .o_irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: FIFO contents as a queue, sticky overrun, expected irq
   logic [DW-1:0] mq[$];
   bit            m_ovr;
   bit            m_irq;
   bit            chk_irq;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("rd_valid", {31'd0, rd_if.rd_valid}, {31'd0, mq.size() != 0});
      chk("level", {28'd0, level}, mq.size());
      chk("rd_data", {23'd0, rd_if.rd_data}, (mq.size() != 0) ? {23'd0, mq[0]} : 32'd0);
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (chk_irq) chk("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   // One clock: drive, let the edge happen, advance the model, check at negedge.
   task automatic step(input bit p, input logic [DW-1:0] d, input bit r, input bit f, input bit oc);
      int sz;
      bit src, pushv, popv, drop;
      rx_done = p; rx_data = d; rd_if.rd_ready = r; flush = f; ovr_clr = oc;
      @(posedge clk);
      sz    = mq.size();
      src   = ((thresh != 0) && (sz >= int'(thresh))) || m_ovr;
      pushv = p && enable;
      popv  = r && (sz != 0);
      drop  = 1'b0;
      if (f) mq.delete();
      else begin
         if (popv) void'(mq.pop_front());
         if (pushv) begin
            if (sz == DEPTH && !popv) drop = 1'b1;
            else mq.push_back(d);
         end
      end
      if (drop) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
      m_irq = src;
      @(negedge clk);
      rx_done = 1'b0; rd_if.rd_ready = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
      check_model();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_tick"}, {31'd0, b_tick}, 0);
      chk({tag, "_valid"}, {31'd0, rd_if.rd_valid}, 0);
      chk({tag, "_level"}, {28'd0, level}, 0);
      chk({tag, "_data"}, {23'd0, rd_if.rd_data}, 0);
      chk({tag, "_ovr"}, {31'd0, overrun}, 0);
      chk({tag, "_to"}, {31'd0, timeout}, 0);
      chk({tag, "_irq"}, {31'd0, irq}, 0);
   endtask

   initial begin
      int ticks;
      resetn = 1'b0; enable = 1'b0; baud_div = '0; rx_done = 1'b0; rx_data = '0;
      rd_if.rd_ready = 1'b0; thresh = '0; to_limit = '0; flush = 1'b0; ovr_clr = 1'b0;
      m_ovr = 1'b0; m_irq = 1'b0; chk_irq = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("rst");
      resetn = 1'b1;
      @(negedge clk);

      // baud tick, divisor 4: ticks on the 4th, 8th, 12th cycle after enable
      baud_div = 16'd4; enable = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk("tick_div4", {31'd0, b_tick}, {31'd0, (n % 4) == 0});
      end
      baud_div = 16'd0;
      ticks = 0;
      for (int n = 0; n < 100; n++) begin @(negedge clk); if (b_tick) ticks++; end
      chk("tick_div0", ticks, 0);
      baud_div = 16'd1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         chk("tick_div1", {31'd0, b_tick}, 1);
      end
      baud_div = 16'd3; enable = 1'b0;
      ticks = 0;
      for (int n = 0; n < 10; n++) begin @(negedge clk); if (b_tick) ticks++; end
      chk("tick_disabled", ticks, 0);
      enable = 1'b1; baud_div = 16'd0;
      @(negedge clk);

      // basic push/pop ordering
      step(1, 9'h1A5, 0, 0, 0);
      step(1, 9'h0FF, 0, 0, 0);
      chk("two_level", {28'd0, level}, 2);
      chk("two_head", {23'd0, rd_if.rd_data}, 9'h1A5);
      step(0, 0, 1, 0, 0);
      chk("pop1_data", {23'd0, rd_if.rd_data}, 9'h0FF);
      step(0, 0, 1, 0, 0);
      chk("pop2_valid", {31'd0, rd_if.rd_valid}, 0);
      // empty + push + pop: only the push happens
      step(1, 9'h055, 1, 0, 0);
      chk("empty_pushpop", {28'd0, level}, 1);
      step(0, 0, 1, 0, 0);

      // overflow: 9 pushes, words 1..8 kept
      for (int i = 1; i <= 9; i++) step(1, 9'(i), 0, 0, 0);
      chk("full_level", {28'd0, level}, 8);
      chk("full_ovr", {31'd0, overrun}, 1);
      step(0, 0, 0, 0, 0);
      chk("ovr_irq", {31'd0, irq}, 1);
      step(0, 0, 0, 0, 1);
      chk("ovr_clr", {31'd0, overrun}, 0);
      // full + push + pop: level holds, new word goes to the tail
      step(1, 9'h1F0, 1, 0, 0);
      chk("full_pp_level", {28'd0, level}, 8);
      chk("full_pp_ovr", {31'd0, overrun}, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
      chk("tail_word", {23'd0, rd_if.rd_data}, 9'h1F0);
      step(0, 0, 1, 0, 0);

      // drop in the same cycle as ovr_clr: set wins
      for (int i = 0; i < 8; i++) step(1, 9'(8'hA0 + i), 0, 0, 0);
      step(1, 9'h1EE, 0, 0, 1);
      chk("drop_vs_clr", {31'd0, overrun}, 1);
      // flush alongside a push
      step(1, 9'h1AA, 0, 1, 0);
      chk("flush_level", {28'd0, level}, 0);
      chk("flush_ovr_kept", {31'd0, overrun}, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      // threshold interrupt
      thresh = 4'd4;
      for (int i = 0; i < 4; i++) step(1, 9'(i + 16), 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("thresh_irq", {31'd0, irq}, 1);

      // asynchronous reset mid-stream
      #2 resetn = 1'b0;
      #1 check_reset("midrst");
      mq.delete(); m_ovr = 1'b0; m_irq = 1'b0;
      @(negedge clk);
      resetn = 1'b1; thresh = 4'd0;
      @(negedge clk);

      // idle timeout: limit 3 ticks, divisor 2, one word sitting in the FIFO
      chk_irq = 1'b0;
      baud_div = 16'd2; to_limit = 8'd3;
      step(1, 9'h123, 0, 0, 0);
      chk("to_c1", {31'd0, timeout}, 0);
      ticks = 0;
      for (int k = 0; k < 40 && ticks < 3; k++) begin
         @(negedge clk);
         chk("to_early", {31'd0, timeout}, 0);
         if (b_tick) ticks++;
      end
      @(negedge clk);
      chk("to_fire", {31'd0, timeout}, 1);
      repeat (3) @(negedge clk);
      chk("to_hold", {31'd0, timeout}, 1);
      step(0, 0, 1, 0, 0);
      chk("to_pop_clr", {31'd0, timeout}, 0);
      to_limit = 8'd0; baud_div = 16'd0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk_irq = 1'b1;

      // randomized traffic against the queue model
      thresh = 4'($urandom_range(0, 8));
      for (int i = 0; i < 400; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         step($urandom_range(0, 9) < 6, 9'($urandom), $urandom_range(0, 9) < 4,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
         if (i == 200) thresh = 4'($urandom_range(1, 8));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
